// File: rtl/matrix_pkg.sv
// Shared definitions for the 5x7 LED matrix scanner: geometry, "all off"
// drive levels, row image type and the column-to-image mapping.
package matrix_pkg;

  localparam int MATRIX_ROWS      = 7;
  localparam int MATRIX_COLS      = 5;
  localparam int MATRIX_HALF_COLS = 3;

  localparam logic [MATRIX_ROWS-1:0] ROWS_OFF = 7'h7F;
  localparam logic [MATRIX_COLS-1:0] COLS_OFF = 5'h1F;

  typedef logic [MATRIX_ROWS-1:0] row_t;
  typedef logic [MATRIX_COLS-1:0] colsel_t;
  typedef logic [$clog2(MATRIX_HALF_COLS)-1:0] img_sel_t;

  // The matrix is left/right symmetric: outer columns share image 2,
  // inner columns share image 1 and the centre column uses image 0.
  function automatic img_sel_t col_to_image(input logic [2:0] col);
    img_sel_t sel;
    case (col)
      3'd0, 3'd4: sel = 2'd2;
      3'd1, 3'd3: sel = 2'd1;
      3'd2:       sel = 2'd0;
      default:    sel = 2'd0;
    endcase
    return sel;
  endfunction

  // Active-low one-hot select for a single column.
  function automatic colsel_t col_select_n(input logic [2:0] col);
    colsel_t onehot;
    onehot = 5'b00001 << col;
    return ~onehot;
  endfunction

endpackage

// File: rtl/matrix_scan_counter.sv
// Column-slot / column-index counter for the matrix scanner. Exposes the
// state the counter will hold after the current edge so that the top level
// can register outputs that line up with the counter state.
import matrix_pkg::*;

module matrix_scan_counter #(
  parameter int SCAN_DIV = 1000,
  parameter int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt_next,
  output logic [2:0]       idx_next,
  output logic             frame_wrap
);

  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic             slot_wrap_s;

  // Next-state: advance within the slot, step column at slot end, hold when disabled
  always_comb begin
    cnt_next    = cnt_r;
    idx_next    = idx_r;
    slot_wrap_s = 1'b0;
    frame_wrap  = 1'b0;
    if (enable) begin
      if (cnt_r == CNT_W'(SCAN_DIV - 1)) begin
        cnt_next    = {CNT_W{1'b0}};
        slot_wrap_s = 1'b1;
        if (idx_r == 3'(MATRIX_COLS - 1)) begin
          idx_next   = 3'd0;
          frame_wrap = slot_wrap_s;
        end else begin
          idx_next = idx_r + 3'd1;
        end
      end else begin
        cnt_next = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_next = cnt_r;
      idx_next = idx_r;
    end
  end

  // Counter state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= 3'd0;
    end else begin
      cnt_r <= cnt_next;
      idx_r <= idx_next;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed scanner for the 5x7 LED matrix. Latches the three
// symmetric column images once per frame, scans one column per slot with a
// blanking gap at the start of every slot, and drives registered outputs.
// Optional blinking is compiled in with the MATRIX_BLINK_EN macro.
import matrix_pkg::*;

module led_matrix_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       blink,
  input  logic [6:0] col_2,
  input  logic [6:0] col_1,
  input  logic [6:0] col_0,
  output logic [4:0] col_sel_n,
  output logic [6:0] row_n,
  output logic       frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_next_s;
  logic [2:0]       idx_next_s;
  logic             frame_wrap_s;
  row_t             img2_r, img1_r, img0_r;
  row_t             img2_next_s, img1_next_s, img0_next_s;
  row_t             row_img_s;
  logic             phase_on_s;
  logic             show_s;

  matrix_scan_counter #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cnt_next   (cnt_next_s),
    .idx_next   (idx_next_s),
    .frame_wrap (frame_wrap_s)
  );

`ifdef MATRIX_BLINK_EN
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FCNT_W-1:0] fcnt_r, fcnt_next_s;
  logic              phase_r, phase_next_s;

  // Count frames and flip the blink phase every BLINK_FRAMES frames
  always_comb begin
    fcnt_next_s  = fcnt_r;
    phase_next_s = phase_r;
    if (frame_wrap_s) begin
      if (fcnt_r == FCNT_W'(BLINK_FRAMES - 1)) begin
        fcnt_next_s  = {FCNT_W{1'b0}};
        phase_next_s = ~phase_r;
      end else begin
        fcnt_next_s = fcnt_r + FCNT_W'(1);
      end
    end else begin
      fcnt_next_s = fcnt_r;
    end
  end

  // Blink frame counter and phase registers; display starts in the on phase
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_r  <= {FCNT_W{1'b0}};
      phase_r <= 1'b1;
    end else begin
      fcnt_r  <= fcnt_next_s;
      phase_r <= phase_next_s;
    end
  end

  assign phase_on_s = ~blink | phase_next_s;
`else
  logic unused_blink_s;
  assign unused_blink_s = blink & (BLINK_FRAMES > 32'sd0);
  assign phase_on_s     = 1'b1;
`endif

  // Pick the image for the column being entered; images swap only at frame wrap
  always_comb begin
    img2_next_s = frame_wrap_s ? col_2 : img2_r;
    img1_next_s = frame_wrap_s ? col_1 : img1_r;
    img0_next_s = frame_wrap_s ? col_0 : img0_r;
    case (col_to_image(idx_next_s))
      2'd2:    row_img_s = img2_next_s;
      2'd1:    row_img_s = img1_next_s;
      default: row_img_s = img0_next_s;
    endcase
    show_s = enable & phase_on_s & (cnt_next_s >= CNT_W'(BLANK_CYCLES));
  end

  // Image latch and registered matrix drive
  always_ff @(posedge clk) begin
    if (reset) begin
      img2_r      <= 7'h00;
      img1_r      <= 7'h00;
      img0_r      <= 7'h00;
      col_sel_n   <= COLS_OFF;
      row_n       <= ROWS_OFF;
      frame_start <= 1'b0;
    end else begin
      img2_r      <= img2_next_s;
      img1_r      <= img1_next_s;
      img0_r      <= img0_next_s;
      frame_start <= frame_wrap_s;
      if (show_s) begin
        col_sel_n <= col_select_n(idx_next_s);
        row_n     <= ~row_img_s;
      end else begin
        col_sel_n <= COLS_OFF;
        row_n     <= ROWS_OFF;
      end
    end
  end

endmodule
